// File: rtl/pcihellocore_pio_pkg.sv
// ---------------------------------------------------------------------------
// pcihellocore_pio_pkg
// Shared definitions for the PCIe hello-core PIO blocks.
//   DATA_W      : Avalon data bus width
//   regAddr_e   : word offsets of the PIO register map
//   cntWidth()  : width of a counter that must hold values 0..cycles
// ---------------------------------------------------------------------------
package pcihellocore_pio_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_IRQMASK = 2'd1,
        ADDR_EDGECAP = 2'd2,
        ADDR_RSVD    = 2'd3
    } regAddr_e;

    // A counter that must reach 'cycles' without wrapping needs
    // clog2(cycles+1) bits; never return less than one bit.
    function automatic int cntWidth(input int cycles);
        if (cycles < 1) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pcihellocore_input_sync_debounce.sv
// ---------------------------------------------------------------------------
// pcihellocore_input_sync_debounce
// Brings an asynchronous input bus into the clk domain through a two-flop
// synchronizer and, when PCIHELLOCORE_BUTTON_DEBOUNCE_EN is defined, filters
// each bit so it only changes after DEBOUNCE_CYCLES consecutive cycles of
// disagreement with the current filtered value.
// Ports:
//   clk_i      : system clock
//   reset_n_i  : synchronous active-low reset
//   inPort_i   : asynchronous inputs (WIDTH bits)
//   stable_o   : synchronized (and optionally debounced) inputs
// Configuration macro: PCIHELLOCORE_BUTTON_DEBOUNCE_EN
// ---------------------------------------------------------------------------
module pcihellocore_input_sync_debounce
    import pcihellocore_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] inPort_i,
    output logic [WIDTH-1:0] stable_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two-flop synchronizer; the first stage may go metastable, the second
    // gives it a full cycle to resolve before anything else looks at it.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= inPort_i;
            sync2_q <= sync2_q ^ (sync2_q ^ sync1_q);
        end
    end

`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN

    localparam int CntW = cntWidth(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    // Each bit counts consecutive cycles where the synchronized input
    // disagrees with the filtered value. The cycle that would make the count
    // reach DEBOUNCE_CYCLES instead adopts the new value and restarts, so the
    // counter never wraps. Any agreeing cycle discards the partial count.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Filtered value and per-bit counters; reset throws away any
    // debounce in progress.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            db_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign stable_o = db_q;

`else

    // Without the filter the parameter has no role; fold it into a sink so
    // it is visibly consumed.
    logic [31:0] unusedDebounce;
    assign unusedDebounce = 32'(DEBOUNCE_CYCLES);

    assign stable_o = sync2_q;

`endif

endmodule

// File: rtl/pcihellocore_button_pio.sv
// ---------------------------------------------------------------------------
// pcihellocore_button_pio
// Avalon-MM input PIO for board pushbuttons/switches. Captures rising edges
// of the synchronized inputs in a sticky write-1-to-clear register and drives
// a registered level interrupt for edges enabled in IRQMASK.
// Register map (word offsets): 0 DATA (RO), 1 IRQMASK (RW),
//                              2 EDGECAP (R/W1C), 3 reserved (reads 0).
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write/select
//   readdata              : combinational read data for 'address'
//   in_port               : asynchronous active-high inputs
//   irq                   : registered level interrupt
// Configuration macro: PCIHELLOCORE_BUTTON_DEBOUNCE_EN enables the per-bit
// debounce filter of DEBOUNCE_CYCLES cycles.
// ---------------------------------------------------------------------------
module pcihellocore_button_pio
    import pcihellocore_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] irqMask_d;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
    logic             irq_q;
    logic             irq_d;
    logic             wrEn;

    // Writedata bits above WIDTH are don't-care.
    logic unusedWdata;
    assign unusedWdata = ^writedata;

    pcihellocore_input_sync_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_syncDebounce (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .inPort_i  (in_port),
        .stable_o  (stable)
    );

    assign wrEn = chipselect & ~write_n;

    // prev starts at 0, so an input already held high when reset is
    // released is seen as a rise once it reaches 'stable'.
    assign rise = stable & ~prev_q;

    // Next-state for the software-visible registers and the interrupt.
    // Edge capture is applied after the W1C clear so a rise arriving on the
    // same edge as its clear is not lost. irq is computed from the current
    // registers, giving one cycle of latency after any register change.
    always_comb begin
        irqMask_d = irqMask_q;
        edgeCap_d = edgeCap_q;
        if (wrEn && (address == ADDR_IRQMASK)) begin
            irqMask_d = writedata[WIDTH-1:0];
        end
        if (wrEn && (address == ADDR_EDGECAP)) begin
            edgeCap_d = edgeCap_q & ~writedata[WIDTH-1:0];
        end
        edgeCap_d = edgeCap_d | rise;
        irq_d     = |(edgeCap_q & irqMask_q);
    end

    // Register state; everything clears on reset so no edge from before
    // reset can be reported afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q    <= '0;
            irqMask_q <= '0;
            edgeCap_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            prev_q    <= stable;
            irqMask_q <= irqMask_d;
            edgeCap_q <= edgeCap_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    // Zero-wait read mux, independent of chipselect and free of side
    // effects; upper bits zero-extend.
    always_comb begin
        readdata = '0;
        case (regAddr_e'(address))
            ADDR_DATA:    readdata = DATA_W'(stable);
            ADDR_IRQMASK: readdata = DATA_W'(irqMask_q);
            ADDR_EDGECAP: readdata = DATA_W'(edgeCap_q);
            ADDR_RSVD:    readdata = '0;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pcihellocore_button_pio.sv
// ---------------------------------------------------------------------------
// tb_pcihellocore_button_pio
// Directed self-checking bench for pcihellocore_button_pio (WIDTH=4). When
// PCIHELLOCORE_BUTTON_DEBOUNCE_EN is defined the DUT is built with
// DEBOUNCE_CYCLES=4 and all latencies stretch by that amount.
// ---------------------------------------------------------------------------
module tb_pcihellocore_button_pio;

`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
    localparam int DbN = 4;
`else
    localparam int DbN = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int totalChecks = 0;
    int badChecks   = 0;

    pcihellocore_button_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES ((DbN == 0) ? 50000 : DbN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkReg(input string tag, input logic [1:0] addr,
                            input logic [31:0] expected);
        address = addr;
        #1;
        checkOutput(tag, readdata, expected);
    endtask

    task automatic applyStimulus(input logic [3:0] value);
        in_port = value;
    endtask

    // Single-cycle Avalon write; takes effect on the next rising edge.
    task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        applyStimulus(4'hF);
        tick(3);

        // Reset state
        checkReg("rstData", 2'd0, 32'h0);
        checkReg("rstMask", 2'd1, 32'h0);
        checkReg("rstEcap", 2'd2, 32'h0);
        checkReg("rstRsvd", 2'd3, 32'h0);
        checkOutput("rstIrq", {31'h0, irq}, 32'h0);

        // Button held through reset is captured after release
        reset_n = 1'b1;
        tick(1 + DbN);
        checkReg("heldDataPre", 2'd0, 32'h0);
        tick(1);
        checkReg("heldData", 2'd0, 32'hF);
        checkReg("heldEcapPre", 2'd2, 32'h0);
        tick(1);
        checkReg("heldEcap", 2'd2, 32'hF);
        checkOutput("heldIrqMasked", {31'h0, irq}, 32'h0);

        // Release and clear; falling edges are not captured
        applyStimulus(4'h0);
        tick(2 + DbN);
        checkReg("relData", 2'd0, 32'h0);
        writeReg(2'd2, 32'hF);
        checkReg("w1cAll", 2'd2, 32'h0);

        // Masked rise on bit 0 raises irq, W1C lowers it
        writeReg(2'd1, 32'h1);
        checkReg("mask1", 2'd1, 32'h1);
        applyStimulus(4'h1);
        tick(2 + DbN);
        checkReg("b0Data", 2'd0, 32'h1);
        tick(1);
        checkReg("b0Ecap", 2'd2, 32'h1);
        checkOutput("b0IrqPre", {31'h0, irq}, 32'h0);
        tick(1);
        checkOutput("b0Irq", {31'h0, irq}, 32'h1);
        tick(6);
        applyStimulus(4'h0);
        tick(3 + DbN);
        checkReg("b0FallEcap", 2'd2, 32'h1);
        checkOutput("b0IrqHeld", {31'h0, irq}, 32'h1);
        writeReg(2'd2, 32'h1);
        checkReg("b0Clr", 2'd2, 32'h0);
        checkOutput("b0IrqLag", {31'h0, irq}, 32'h1);
        tick(1);
        checkOutput("b0IrqOff", {31'h0, irq}, 32'h0);

        // Unmasked capture, then enabling the mask raises irq one edge later
        writeReg(2'd1, 32'h2);
        applyStimulus(4'h1);
        tick(3 + DbN);
        checkReg("unmEcap", 2'd2, 32'h1);
        tick(2);
        checkOutput("unmIrq", {31'h0, irq}, 32'h0);
        writeReg(2'd1, 32'h3);
        checkOutput("maskIrqLag", {31'h0, irq}, 32'h0);
        tick(1);
        checkOutput("maskIrq", {31'h0, irq}, 32'h1);

        // Rise on bit 2 lands on the same edge as its W1C: set wins
        applyStimulus(4'h5);
        tick(2 + DbN);
        writeReg(2'd2, 32'h4);
        checkReg("setWins", 2'd2, 32'h5);
        tick(1);
        checkReg("setWinsHold", 2'd2, 32'h5);

        // Writes to DATA and reserved offsets are ignored
        writeReg(2'd0, 32'hFFFF_FFFF);
        writeReg(2'd3, 32'hFFFF_FFFF);
        checkReg("roData", 2'd0, 32'h5);
        checkReg("roMask", 2'd1, 32'h3);
        checkReg("roEcap", 2'd2, 32'h5);
        checkReg("roRsvd", 2'd3, 32'h0);
        writeReg(2'd1, 32'hFFFF_FFFF);
        checkReg("maskUpper", 2'd1, 32'hF);

        // Clear with inputs still high, then drop them: nothing recaptured
        writeReg(2'd2, 32'hF);
        checkReg("clrHeld", 2'd2, 32'h0);
        tick(1);
        checkOutput("clrIrq", {31'h0, irq}, 32'h0);
        applyStimulus(4'h0);
        tick(4 + DbN);
        checkReg("fallEcap", 2'd2, 32'h0);
        checkOutput("fallIrq", {31'h0, irq}, 32'h0);

`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
        // Three-cycle glitch on bit 1 is filtered out
        applyStimulus(4'h2);
        tick(3);
        applyStimulus(4'h0);
        tick(10);
        checkReg("glitchData", 2'd0, 32'h0);
        checkReg("glitchEcap", 2'd2, 32'h0);

        // Held high long enough passes through
        applyStimulus(4'h2);
        tick(5);
        checkReg("dbDataPre", 2'd0, 32'h0);
        tick(1);
        checkReg("dbData", 2'd0, 32'h2);
        checkReg("dbEcapPre", 2'd2, 32'h0);
        tick(1);
        checkReg("dbEcap", 2'd2, 32'h2);
        tick(4);
        applyStimulus(4'h0);
        tick(8);
`endif

        // Reset in the middle of activity clears everything
        writeReg(2'd1, 32'hF);
        applyStimulus(4'hF);
        tick(3 + DbN);
        checkReg("preRstEcap", 2'd2, 32'hF);
        reset_n = 1'b0;
        tick(1);
        checkReg("midRstData", 2'd0, 32'h0);
        checkReg("midRstMask", 2'd1, 32'h0);
        checkReg("midRstEcap", 2'd2, 32'h0);
        checkOutput("midRstIrq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
